array_allocator: RTL

Hardware array allocator and length tracker for the heap. It hands out array numbers and recycles freed ones through a LIFO stack. It keeps the per-array element count (`arraySizes`) that the array instructions (arrayCountLess and others) use to bound their scans over `heapMem[array*NArea + i]`. It sits upstream of every array-consuming instruction and is driven by the instruction sequencer's `array`, `free` and heap-store operations.

---
 rtl/array_allocator.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/array_allocator.sv
// Array number allocator with a LIFO recycle stack and per-array length tracking.
// After reset, a clear sweep zeroes sizes and in-use bits, one array per cycle,
// before any request is accepted.
module array_allocator #(
  parameter int unsigned MemoryElementWidth = 12,
  parameter int unsigned NArrays            = 16,
  parameter int unsigned NArea              = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  output logic                          ready,
  input  logic                          alloc_req,
  input  logic                          free_req,
  input  logic [MemoryElementWidth-1:0] free_array,
  input  logic                          upd_req,
  input  logic [MemoryElementWidth-1:0] upd_array,
  input  logic [MemoryElementWidth-1:0] upd_index,
  input  logic [MemoryElementWidth-1:0] size_array,
  output logic [MemoryElementWidth-1:0] size,
  output logic                          alloc_done,
  output logic [MemoryElementWidth-1:0] alloc_array,
  output logic                          err_full,
  output logic                          err_free,
  output logic                          err_upd,
  output logic [MemoryElementWidth-1:0] in_use,
  output logic [MemoryElementWidth-1:0] high_water
);

  localparam int unsigned W  = MemoryElementWidth;
  localparam int unsigned AW = (NArrays > 1) ? $clog2(NArrays) : 1;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;

  logic [0:0]   r_state;
  logic [0:0]   w_state_next;
  logic [AW-1:0] r_clear_idx;

  logic [W-1:0]       r_sizes [NArrays];
  logic [W-1:0]       r_stack [NArrays];
  logic [NArrays-1:0] r_inuse;
  logic [W-1:0]       r_top;
  logic [W-1:0]       r_allocs;
  logic [W-1:0]       r_in_use;

  logic         r_alloc_done;
  logic [W-1:0] r_alloc_arr;
  logic         r_err_full;
  logic         r_err_free;
  logic         r_err_upd;
  logic [W-1:0] r_size;

  logic          w_idle;
  logic          w_top_nz;
  logic          w_fresh_ok;
  logic          w_alloc_ok;
  logic          w_alloc_fail;
  logic          w_pop;
  logic [W-1:0]  w_top_m1;
  logic [W-1:0]  w_alloc_arr;
  logic [AW-1:0] w_alloc_idx;
  logic [AW-1:0] w_free_idx;
  logic          w_free_legal;
  logic          w_free_ok;
  logic          w_free_fail;
  logic [AW-1:0] w_push_idx;
  logic [AW-1:0] w_upd_idx;
  logic          w_upd_legal;
  logic          w_upd_ok;
  logic          w_upd_fail;
  logic [W-1:0]  w_upd_len;

  // Request qualification, all against the state at the start of the cycle
  assign w_idle       = (r_state == S_IDLE);
  assign w_top_nz     = (r_top != '0);
  assign w_fresh_ok   = (r_allocs < W'(NArrays));
  assign w_alloc_ok   = w_idle & alloc_req & (w_top_nz | w_fresh_ok);
  assign w_alloc_fail = w_idle & alloc_req & ~(w_top_nz | w_fresh_ok);
  assign w_pop        = w_alloc_ok & w_top_nz;
  assign w_top_m1     = r_top - W'(1);
  assign w_alloc_arr  = w_pop ? r_stack[AW'(w_top_m1)] : r_allocs;
  assign w_alloc_idx  = AW'(w_alloc_arr);

  assign w_free_idx   = AW'(free_array);
  assign w_free_legal = (free_array < W'(NArrays)) & r_inuse[w_free_idx];
  assign w_free_ok    = w_idle & free_req & w_free_legal;
  assign w_free_fail  = w_idle & free_req & ~w_free_legal;
  // A simultaneous pop frees slot top-1, so the push reuses it
  assign w_push_idx   = w_pop ? AW'(w_top_m1) : AW'(r_top);

  assign w_upd_idx    = AW'(upd_array);
  assign w_upd_legal  = (upd_array < W'(NArrays)) & r_inuse[w_upd_idx]
                      & ~(w_free_ok & (free_array == upd_array))
                      & (upd_index < W'(NArea));
  assign w_upd_ok     = w_idle & upd_req & w_upd_legal;
  assign w_upd_fail   = w_idle & upd_req & ~w_upd_legal;
  assign w_upd_len    = upd_index + W'(1);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: leave the sweep after the last array is cleared
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_CLEAR: if (r_clear_idx == AW'(NArrays - 1)) w_state_next = S_IDLE;
      default: w_state_next = r_state;
    endcase
  end

  // Control counters and registered responses
  always_ff @(posedge clock) begin
    if (reset) begin
      r_clear_idx  <= '0;
      r_top        <= '0;
      r_allocs     <= '0;
      r_in_use     <= '0;
      r_alloc_done <= 1'b0;
      r_alloc_arr  <= '0;
      r_err_full   <= 1'b0;
      r_err_free   <= 1'b0;
      r_err_upd    <= 1'b0;
      r_size       <= '0;
    end else begin
      if (r_state == S_CLEAR) r_clear_idx <= r_clear_idx + AW'(1);
      r_alloc_done <= w_alloc_ok;
      if (w_alloc_ok) r_alloc_arr <= w_alloc_arr;
      r_err_full <= w_alloc_fail;
      r_err_free <= w_free_fail;
      r_err_upd  <= w_upd_fail;
      r_size     <= (size_array < W'(NArrays)) ? r_sizes[AW'(size_array)] : '0;
      if (w_alloc_ok && !w_pop) r_allocs <= r_allocs + W'(1);
      case ({w_pop, w_free_ok})
        2'b10:   r_top <= r_top - W'(1);
        2'b01:   r_top <= r_top + W'(1);
        default: r_top <= r_top;
      endcase
      case ({w_alloc_ok, w_free_ok})
        2'b10:   r_in_use <= r_in_use + W'(1);
        2'b01:   r_in_use <= r_in_use - W'(1);
        default: r_in_use <= r_in_use;
      endcase
    end
  end

  // Per-array storage: sweep clear, then alloc/free/update writes
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (r_state == S_CLEAR) begin
        r_sizes[r_clear_idx] <= '0;
        r_inuse[r_clear_idx] <= 1'b0;
      end else begin
        if (w_upd_ok && (r_sizes[w_upd_idx] < w_upd_len)) r_sizes[w_upd_idx] <= w_upd_len;
        if (w_alloc_ok) begin
          r_sizes[w_alloc_idx] <= '0;
          r_inuse[w_alloc_idx] <= 1'b1;
        end
        if (w_free_ok) begin
          r_inuse[w_free_idx]  <= 1'b0;
          r_stack[w_push_idx]  <= free_array;
        end
      end
    end
  end

  assign ready       = w_idle;
  assign size        = r_size;
  assign alloc_done  = r_alloc_done;
  assign alloc_array = r_alloc_arr;
  assign err_full    = r_err_full;
  assign err_free    = r_err_free;
  assign err_upd     = r_err_upd;
  assign in_use      = r_in_use;
  assign high_water  = r_allocs;

endmodule
